seven_seg_capture: RTL and testbench

Receive side of the multiplexed seven-segment bus driven by the stopwatch display controller. The block samples the 8-bit bus (7 active-low segments plus a digit-select bit) and debounces each multiplexed phase. It decodes the segment pattern back to a 4-bit nibble and pairs one LSB phase with one MSB phase to present the full 8-bit display value. It serves as a loopback checker on the stopwatch display path and as a capture front end when reading an external two-digit display.

---
 rtl/seven_seg_capture_pkg.sv | 34 +++
 rtl/seven_seg_capture_decode.sv | 25 ++
 rtl/seven_seg_capture.sv | 144 ++++++++++++++
 tb/tb_seven_seg_capture.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/seven_seg_capture_pkg.sv
// Shared constants and types for the seven-segment bus capture block:
// glyph table (inverse of the hex-to-segment converter), digit select and pairing states.
package seven_seg_capture_pkg;

  localparam logic       SEL_LSB       = 1'b1;
  localparam logic [6:0] BLANK_PATTERN = 7'b0000000;

  // Active-high segment patterns {g,f,e,d,c,b,a}, indexed by nibble value.
  localparam logic [15:0][6:0] GLYPH = {
    7'b1110001,  // F
    7'b1111001,  // E
    7'b1011110,  // D
    7'b0111001,  // C
    7'b1111100,  // B
    7'b1110111,  // A
    7'b1101111,  // 9
    7'b1111111,  // 8
    7'b0000111,  // 7
    7'b1111101,  // 6
    7'b1101101,  // 5
    7'b1100110,  // 4
    7'b1001111,  // 3
    7'b1011011,  // 2
    7'b0000110,  // 1
    7'b0111111   // 0
  };

  typedef enum logic [1:0] {
    WAIT_ANY,
    GOT_LSB,
    GOT_MSB
  } pair_state_e;

endpackage

// File: rtl/seven_seg_capture_decode.sv
// Combinational segment-pattern to nibble decoder; flags blank and illegal patterns.
module seven_seg_decode
  import seven_seg_capture_pkg::*;
(
  input  logic [6:0] pattern,
  output logic [3:0] nibble,
  output logic       legal,
  output logic       blank
);

  // NOTE: every output of an always_comb gets a default first, so no path infers a latch.
  always_comb begin
    nibble = 4'h0;
    legal  = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (pattern == GLYPH[i]) begin
        nibble = 4'(i);
        legal  = 1'b1;
      end
    end
  end

  assign blank = (pattern == BLANK_PATTERN);

endmodule

// File: rtl/seven_seg_capture.sv
// Receive side of the multiplexed seven-segment bus: synchronise, debounce each phase,
// decode the glyph and pair one LSB and one MSB digit into an 8-bit value.
module seven_seg_capture
  import seven_seg_capture_pkg::*;
#(
  parameter int STABLE_CYCLES = 16
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic [7:0] seg_in,
  output logic [7:0] value,
  output logic       valid,
  output logic       err
);

  localparam int            CW      = $clog2(STABLE_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES - 1);

  logic [7:0]    sync1, s, s_prev, acc_seg;
  logic [CW-1:0] stab_cnt, stab_cnt_d;
  logic          acc, acc_d;

  always_comb begin
    stab_cnt_d = stab_cnt;
    if (s != s_prev)
      stab_cnt_d = '0;
    else if (stab_cnt != CNT_MAX)
      stab_cnt_d = stab_cnt + 1'b1;
  end

  // Fires only on the transition into saturation: one accept per stable period.
  assign acc_d = (stab_cnt != CNT_MAX) && (stab_cnt_d == CNT_MAX);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RST) begin
      sync1    <= 8'hFF;
      s        <= 8'hFF;
      s_prev   <= 8'hFF;
      stab_cnt <= '0;
      acc      <= 1'b0;
      acc_seg  <= 8'hFF;
    end else begin
      sync1    <= seg_in;
      s        <= sync1;
      s_prev   <= s;
      stab_cnt <= stab_cnt_d;
      acc      <= acc_d;
      acc_seg  <= s;
    end
  end

  logic [6:0] acc_pattern;
  logic [3:0] nibble;
  logic       legal, blank, sel;

  assign acc_pattern = ~acc_seg[6:0];
  assign sel         = acc_seg[7];

  seven_seg_decode u_decode (
    .pattern(acc_pattern),
    .nibble (nibble),
    .legal  (legal),
    .blank  (blank)
  );

  pair_state_e state, state_d;
  logic [3:0]  lsb_hold, msb_hold;
  logic [7:0]  value_d;
  logic        valid_d, err_d, load_lsb, load_msb, clear_holds, take;

  // Blank patterns are accepted by the filter but never disturb the pairing.
  assign take = acc && !blank;

  always_ff @(posedge CLK) begin
    if (RST) state <= WAIT_ANY;
    else     state <= state_d;
  end

  always_comb begin
    state_d = state;
    if (take) begin
      if (!legal) begin
        state_d = WAIT_ANY;
      end else begin
        case (state)
          WAIT_ANY: state_d = (sel == SEL_LSB) ? GOT_LSB  : GOT_MSB;
          GOT_LSB:  state_d = (sel == SEL_LSB) ? GOT_LSB  : WAIT_ANY;
          GOT_MSB:  state_d = (sel == SEL_LSB) ? WAIT_ANY : GOT_MSB;
          default:  state_d = WAIT_ANY;
        endcase
      end
    end
  end

  always_comb begin
    valid_d     = 1'b0;
    err_d       = 1'b0;
    load_lsb    = 1'b0;
    load_msb    = 1'b0;
    clear_holds = 1'b0;
    value_d     = value;
    if (take) begin
      if (!legal) begin
        err_d       = 1'b1;
        clear_holds = 1'b1;
      end else if (sel == SEL_LSB) begin
        load_lsb = 1'b1;
        if (state == GOT_MSB) begin
          valid_d = 1'b1;
          value_d = {msb_hold, nibble};
        end
      end else begin
        load_msb = 1'b1;
        if (state == GOT_LSB) begin
          valid_d = 1'b1;
          value_d = {nibble, lsb_hold};
        end
      end
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      value    <= 8'h00;
      valid    <= 1'b0;
      err      <= 1'b0;
      lsb_hold <= 4'h0;
      msb_hold <= 4'h0;
    end else begin
      value <= value_d;
      valid <= valid_d;
      err   <= err_d;
      if (clear_holds) begin
        lsb_hold <= 4'h0;
        msb_hold <= 4'h0;
      end else begin
        if (load_lsb) lsb_hold <= nibble;
        if (load_msb) msb_hold <= nibble;
      end
    end
  end

endmodule

// File: tb/tb_seven_seg_capture.sv
// Directed bench for seven_seg_capture: expected valid/err events are queued when a phase
// is driven and matched (kind, value, cycle) as the DUT pulses its outputs.
module tb_seven_seg_capture;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] seg_in;
  logic [7:0] value;
  logic       valid;
  logic       err;

  always #5 CLK = ~CLK;

  seven_seg_capture #(.STABLE_CYCLES(16)) dut (
    .CLK   (CLK),
    .RST   (RST),
    .seg_in(seg_in),
    .value (value),
    .valid (valid),
    .err   (err)
  );

  // Independent glyph table, active-high {g..a}.
  localparam logic [6:0] SEGS [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  // Registered pulse appears on edge E0 + STABLE_CYCLES + 2; E0 is the first edge after driving.
  localparam int LATENCY = 16 + 3;

  typedef struct {
    logic       is_err;
    logic [7:0] value;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;
  int   events   = 0;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [7:0] bus(input logic lsb, input int d);
    logic [6:0] g;
    g = SEGS[d];
    return {lsb, ~g};
  endfunction

  task automatic expect_ev(input logic is_err, input logic [7:0] v);
    exp_t e;
    e.is_err = is_err;
    e.value  = v;
    e.at     = cyc + LATENCY;
    sb.push_back(e);
  endtask

  task automatic drive(input logic [7:0] v, input int n);
    seg_in = v;
    repeat (n) @(negedge CLK);
  endtask

  always @(negedge CLK) begin
    if (valid || err) begin
      exp_t e;
      events++;
      check("valid_err_exclusive", 32'(valid && err), 0);
      check("event_expected", 32'(sb.size() > 0), 1);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("event_is_err", 32'(err), 32'(e.is_err));
        check("event_value", 32'(value), 32'(e.value));
        check("event_cycle", 32'(cyc), 32'(e.at));
      end
    end
  end

  initial begin
    int ev0;
    RST    = 1'b1;
    seg_in = 8'hFF;
    repeat (3) @(negedge CLK);
    check("reset_value", 32'(value), 0);
    check("reset_valid", 32'(valid), 0);
    check("reset_err", 32'(err), 0);
    RST = 1'b0;
    drive(8'hFF, 30);

    // Basic pair: LSB '5' then MSB '3'.
    drive(bus(1'b1, 5), 100);
    expect_ev(1'b0, 8'h35);
    drive(bus(1'b0, 3), 100);
    check("pair_value", 32'(value), 32'h35);
    check("pair_drained", 32'(sb.size()), 0);

    // Short LSB '1' glitch inside an LSB '5' phase must not replace the held nibble.
    drive(bus(1'b1, 5), 40);
    drive(bus(1'b1, 1), 10);
    drive(bus(1'b1, 5), 10);
    expect_ev(1'b0, 8'h35);
    drive(bus(0, 3), 100);
    check("glitch_value", 32'(value), 32'h35);

    // Illegal pattern discards the held LSB '7'; value untouched.
    drive(bus(1'b1, 7), 100);
    expect_ev(1'b1, 8'h35);
    drive({1'b1, ~7'b1010101}, 50);
    check("illegal_value_kept", 32'(value), 32'h35);
    drive(bus(1'b0, 4), 100);
    expect_ev(1'b0, 8'h42);
    drive(bus(1'b1, 2), 100);
    check("after_illegal_value", 32'(value), 32'h42);

    // Blank bus is ignored.
    ev0 = events;
    drive(8'hFF, 500);
    check("blank_no_events", 32'(events - ev0), 0);
    check("blank_value_kept", 32'(value), 32'h42);

    // Reset in the middle of the next LSB phase drops the partial pair.
    drive(bus(1'b1, 5), 100);
    expect_ev(1'b0, 8'h35);
    drive(bus(1'b0, 3), 100);
    drive(bus(1'b1, 5), 50);
    RST = 1'b1;
    @(negedge CLK);
    check("midreset_value", 32'(value), 0);
    check("midreset_valid", 32'(valid), 0);
    check("midreset_err", 32'(err), 0);
    RST = 1'b0;
    drive(bus(1'b0, 4), 100);
    expect_ev(1'b0, 8'h42);
    drive(bus(1'b1, 2), 100);
    check("postreset_value", 32'(value), 32'h42);

    // Loopback at display-controller rate: 8'h99 then 8'h00.
    drive(bus(1'b1, 9), 1024);
    expect_ev(1'b0, 8'h99);
    drive(bus(1'b0, 9), 1024);
    check("loop_value_99", 32'(value), 32'h99);
    drive(bus(1'b1, 0), 1024);
    expect_ev(1'b0, 8'h00);
    drive(bus(1'b0, 0), 1024);
    check("loop_value_00", 32'(value), 0);

    repeat (30) @(negedge CLK);
    check("scoreboard_drained", 32'(sb.size()), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
